neural_net_controller: RTL and testbench

- Fixed-weight 4-input, 3-hidden, 2-output multilayer perceptron for mine detection.
- The four binary sensor switches feed the network. It produces two signed Q8.8 scores: rezultat_1 is the "mine" score and rezultat_2 is the "clear" score.
- Each score also drives a threshold indicator LED.
- Top-level block between the board switches/LEDs and any result display logic.

---
 rtl/nn_pkg.sv | 45 ++++
 rtl/nn_neuron.sv | 27 ++
 rtl/neural_net_controller.sv | 83 ++++++++
 tb/tb_neural_net_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared Q8.8 types, arithmetic helpers and default weights for the mine-detection MLP.
package nn_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam int unsigned FRAC_BITS = 8;
  localparam q8_8_t       Q_ONE     = 16'sh0100;

  localparam int unsigned N_INPUTS  = 4;
  localparam int unsigned N_HIDDEN  = 3;
  localparam int unsigned N_OUTPUTS = 2;

  // Element [j][i] is the weight from input i into neuron j.
  typedef logic [0:N_HIDDEN-1][0:N_INPUTS-1][15:0]  w1_t;
  typedef logic [0:N_HIDDEN-1][15:0]                b1_t;
  typedef logic [0:N_OUTPUTS-1][0:N_HIDDEN-1][15:0] w2_t;
  typedef logic [0:N_OUTPUTS-1][15:0]               b2_t;

  localparam w1_t W1_DEFAULT = '{
    '{16'h0100, 16'h0100, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0100, 16'h0100},
    '{16'h0080, 16'h0080, 16'h0080, 16'h0080}
  };
  localparam b1_t B1_DEFAULT = '{16'hFF00, 16'hFF00, 16'h0000};
  localparam w2_t W2_DEFAULT = '{
    '{16'h0100, 16'h0100, 16'h0040},
    '{16'h0000, 16'h0000, 16'hFF00}
  };
  localparam b2_t   B2_DEFAULT     = '{16'h0000, 16'h0100};
  localparam q8_8_t THRESH_DEFAULT = 16'sh0080;

  function automatic q8_8_t sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end
    return v[15:0];
  endfunction

  function automatic q8_8_t relu(input q8_8_t v);
    return v[15] ? '0 : v;
  endfunction

endpackage

// File: rtl/nn_neuron.sv
// Combinational neuron: Q8.8 multiply-accumulate with bias, then saturate and ReLU.
module nn_neuron
  import nn_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic [0:N_IN-1][15:0] w,
  input  logic [0:N_IN-1][15:0] x,
  input  q8_8_t                 bias,
  output q8_8_t                 y
);

  logic signed [31:0] acc;
  logic signed [31:0] prod;

  always_comb begin
    acc  = {{16{bias[15]}}, bias};
    prod = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      prod = 32'($signed(w[i])) * 32'($signed(x[i]));
      // Arithmetic shift drops the extra fraction bits, rounding toward -inf.
      acc  = acc + (prod >>> FRAC_BITS);
    end
    y = relu(sat16(acc));
  end

endmodule

// File: rtl/neural_net_controller.sv
// Three-stage pipelined 4-3-2 perceptron: input register, hidden layer, output layer + LEDs.
module neural_net_controller
  import nn_pkg::*;
#(
  parameter w1_t   W1     = W1_DEFAULT,
  parameter b1_t   B1     = B1_DEFAULT,
  parameter w2_t   W2     = W2_DEFAULT,
  parameter b2_t   B2     = B2_DEFAULT,
  parameter q8_8_t THRESH = THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        switch_1,
  input  logic        switch_2,
  input  logic        switch_3,
  input  logic        switch_4,
  output logic        indikator_1,
  output logic        indikator_2,
  output logic [15:0] rezultat_1,
  output logic [15:0] rezultat_2
);

  logic [0:N_INPUTS-1]         x_q;
  logic [0:N_INPUTS-1][15:0]   x_vec;
  logic [0:N_HIDDEN-1][15:0]   h_d, h_q;
  logic [0:N_OUTPUTS-1][15:0]  y_d, y_q;
  logic [0:N_OUTPUTS-1]        ind_d, ind_q;

  always_comb begin
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      x_vec[i] = x_q[i] ? Q_ONE : '0;
    end
  end

  for (genvar j = 0; j < N_HIDDEN; j++) begin : g_hidden
    nn_neuron #(
      .N_IN (N_INPUTS)
    ) u_neuron (
      .w    (W1[j]),
      .x    (x_vec),
      .bias (B1[j]),
      .y    (h_d[j])
    );
  end

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_output
    nn_neuron #(
      .N_IN (N_HIDDEN)
    ) u_neuron (
      .w    (W2[k]),
      .x    (h_q),
      .bias (B2[k]),
      .y    (y_d[k])
    );
  end

  // Compared before the output register so each LED stays coherent with its score.
  always_comb begin
    for (int k = 0; k < int'(N_OUTPUTS); k++) begin
      ind_d[k] = $signed(y_d[k]) >= THRESH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      h_q   <= '0;
      y_q   <= '0;
      ind_q <= '0;
    end else begin
      x_q   <= {switch_1, switch_2, switch_3, switch_4};
      h_q   <= h_d;
      y_q   <= y_d;
      ind_q <= ind_d;
    end
  end

  assign rezultat_1  = y_q[0];
  assign rezultat_2  = y_q[1];
  assign indikator_1 = ind_q[0];
  assign indikator_2 = ind_q[1];

endmodule

// File: tb/tb_neural_net_controller.sv
// Directed bench for neural_net_controller with hand-computed Q8.8 expectations.
module tb_neural_net_controller;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        switch_1, switch_2, switch_3, switch_4;
  logic        indikator_1, indikator_2;
  logic [15:0] rezultat_1, rezultat_2;
  logic        sat_ind_1, sat_ind_2;
  logic [15:0] sat_rez_1, sat_rez_2;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected scores indexed by code {switch_1, switch_2, switch_3, switch_4}.
  localparam logic [15:0] EXP_Y1 [16] = '{
    16'h0000, 16'h0020, 16'h0020, 16'h0140, 16'h0020, 16'h0040, 16'h0040, 16'h0160,
    16'h0020, 16'h0040, 16'h0040, 16'h0160, 16'h0140, 16'h0160, 16'h0160, 16'h0280
  };
  localparam logic [15:0] EXP_Y2 [16] = '{
    16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000,
    16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };
  logic [15:0] led1_mask = 16'hF888;
  logic [15:0] led2_mask = 16'h0117;

  localparam w2_t W2_SAT = '{
    '{16'h7FFF, 16'h7FFF, 16'h7FFF},
    '{16'h0000, 16'h0000, 16'hFF00}
  };

  always #5 clk = ~clk;

  neural_net_controller u_dut (
    .clk         (clk),
    .rst         (rst),
    .switch_1    (switch_1),
    .switch_2    (switch_2),
    .switch_3    (switch_3),
    .switch_4    (switch_4),
    .indikator_1 (indikator_1),
    .indikator_2 (indikator_2),
    .rezultat_1  (rezultat_1),
    .rezultat_2  (rezultat_2)
  );

  neural_net_controller #(
    .W2 (W2_SAT)
  ) u_dut_sat (
    .clk         (clk),
    .rst         (rst),
    .switch_1    (switch_1),
    .switch_2    (switch_2),
    .switch_3    (switch_3),
    .switch_4    (switch_4),
    .indikator_1 (sat_ind_1),
    .indikator_2 (sat_ind_2),
    .rezultat_1  (sat_rez_1),
    .rezultat_2  (sat_rez_2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic set_code(input logic [3:0] code);
    {switch_1, switch_2, switch_3, switch_4} = code;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_code(input string tag, input logic [3:0] code);
    check({tag, ".r1"}, rezultat_1, EXP_Y1[code]);
    check({tag, ".r2"}, rezultat_2, EXP_Y2[code]);
    check({tag, ".i1"}, {15'd0, indikator_1}, {15'd0, led1_mask[code]});
    check({tag, ".i2"}, {15'd0, indikator_2}, {15'd0, led2_mask[code]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".r1"}, rezultat_1, 16'h0000);
    check({tag, ".r2"}, rezultat_2, 16'h0000);
    check({tag, ".i1"}, {15'd0, indikator_1}, 16'h0000);
    check({tag, ".i2"}, {15'd0, indikator_2}, 16'h0000);
  endtask

  logic [3:0] seq [6];

  initial begin
    rst = 1'b1;
    set_code(4'b1111);
    step(3);
    check_all_zero("reset");

    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("post_rst.r1", rezultat_1, 16'h0000);
    check("post_rst.r2", rezultat_2, 16'h0100);
    check("post_rst.i2", {15'd0, indikator_2}, 16'h0001);

    // Full sweep, each code settled for three edges.
    for (int c = 0; c < 16; c++) begin
      set_code(4'(c));
      step(3);
      check_code($sformatf("sweep_%0d", c), 4'(c));
    end

    // Latency: old values hold for two edges, new ones appear on the third.
    set_code(4'b0000);
    step(3);
    set_code(4'b1111);
    step(1);
    check_code("lat_e1", 4'b0000);
    step(1);
    check_code("lat_e2", 4'b0000);
    step(1);
    check_code("lat_e3", 4'b1111);

    // Back-to-back changes: outputs trail the inputs by a fixed three edges.
    seq = '{4'b0001, 4'b1100, 4'b0000, 4'b1111, 4'b1010, 4'b0111};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) set_code(seq[i]);
      step(1);
      if (i >= 2) check_code($sformatf("b2b_%0d", i - 2), seq[i - 2]);
    end

    // Saturated output weights must clamp rather than wrap.
    set_code(4'b1111);
    step(3);
    check("sat.r1", sat_rez_1, 16'h7FFF);
    check("sat.i1", {15'd0, sat_ind_1}, 16'h0001);
    check("sat.r2", sat_rez_2, 16'h0000);

    // Asynchronous reset between edges with a full pipeline.
    check_code("pre_mid_rst", 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    check("mid_rst.sat", sat_rez_1, 16'h0000);
    #1;
    rst = 1'b0;
    step(1);
    check("mid_e1.r1", rezultat_1, 16'h0000);
    check("mid_e1.r2", rezultat_2, 16'h0100);
    step(1);
    check("mid_e2.r1", rezultat_1, 16'h0000);
    check("mid_e2.r2", rezultat_2, 16'h0100);
    step(1);
    check_code("mid_e3", 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
